// File: rtl/dmem_responder.sv
// dmem_responder: memory end of the processor load/store interface.
// Big-endian, byte-addressed array of 32-bit words. Every access walks
// IDLE -> BUSY (WAIT_STATES+1 cycles) -> DONE, with a one-cycle ack in DONE.
// Stores read-modify-write only the addressed lanes; loads extract the addressed
// lanes right-justified, then sign- or zero-extend them.
// Bit 0 of every [0:31] bus is the MSB and bit 31 is the LSB.
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_req                 access request, sampled in IDLE only
//   i_addr                byte address
//   i_data_in             store data (sub-word data right-justified)
//   i_write_enable        1 = store, 0 = load
//   i_byte, i_half_word   access size (byte wins over half_word)
//   i_sign_extend         sub-word load extension select
//   o_data_out            load result, held until the next completion
//   o_ack                 one-cycle completion pulse
//   o_busy                high in BUSY and DONE
//   o_misaligned          pulses with ack for a misaligned access
module dmem_responder #(
  parameter int unsigned ADDR_WORDS_LOG2 = 10,
  parameter int unsigned WAIT_STATES     = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic [0:31] i_addr,
  input  logic [0:31] i_data_in,
  input  logic        i_write_enable,
  input  logic        i_byte,
  input  logic        i_half_word,
  input  logic        i_sign_extend,
  output logic [0:31] o_data_out,
  output logic        o_ack,
  output logic        o_busy,
  output logic        o_misaligned
);

  localparam int unsigned Depth = 1 << ADDR_WORDS_LOG2;
  localparam int unsigned CntW  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

  state_t              r_state;
  logic [CntW-1:0]     r_cnt;
  logic [0:31]         r_addr;
  logic [0:31]         r_data;
  logic                r_we;
  logic                r_byte;
  logic                r_half;
  logic                r_sext;
  logic [0:31]         r_mem [0:Depth-1];

  logic [ADDR_WORDS_LOG2-1:0] w_idx;
  logic [1:0]                 w_off;
  logic                       w_cnt_done;
  logic                       w_mis;
  logic                       w_commit;
  logic [0:31]                w_rd;
  logic [0:31]                w_wr;
  logic [0:31]                w_load;
  logic [0:7]                 w_b;
  logic [0:15]                w_h;
  int unsigned                w_bbase;
  int unsigned                w_hbase;

  // Upper address bits above the array depth are dropped, so addresses wrap.
  assign w_idx      = r_addr[30-ADDR_WORDS_LOG2 : 29];
  assign w_off      = r_addr[30:31];
  assign w_cnt_done = (r_cnt == CntW'(WAIT_STATES));
  assign w_rd       = r_mem[w_idx];
  assign w_bbase    = 8 * int'(w_off);
  assign w_hbase    = 16 * int'(w_off[1]);

  always_comb begin
    w_mis = 1'b0;
    if (!r_byte) begin
      if (r_half) w_mis = w_off[0];
      else        w_mis = |w_off;
    end
  end

  assign w_commit = (r_state == StBusy) && w_cnt_done && r_we && !w_mis;

  // Lane merge for stores and lane extract/extend for loads.
  always_comb begin
    w_b    = w_rd[w_bbase +: 8];
    w_h    = w_rd[w_hbase +: 16];
    w_wr   = w_rd;
    w_load = w_rd;
    if (r_byte) begin
      w_wr[w_bbase +: 8] = r_data[24:31];
      w_load             = {{24{r_sext & w_b[0]}}, w_b};
    end else if (r_half) begin
      w_wr[w_hbase +: 16] = r_data[16:31];
      w_load              = {{16{r_sext & w_h[0]}}, w_h};
    end else begin
      w_wr = r_data;
    end
  end

  // Array has no reset; a reset landing on the commit edge suppresses the write.
  always_ff @(posedge i_clk) begin
    if (w_commit && !i_reset) r_mem[w_idx] <= w_wr;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_we         <= 1'b0;
      r_byte       <= 1'b0;
      r_half       <= 1'b0;
      r_sext       <= 1'b0;
      o_data_out   <= '0;
      o_ack        <= 1'b0;
      o_busy       <= 1'b0;
      o_misaligned <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_req) begin
            r_state <= StBusy;
            r_cnt   <= '0;
            r_addr  <= i_addr;
            r_data  <= i_data_in;
            r_we    <= i_write_enable;
            r_byte  <= i_byte;
            r_half  <= i_half_word;
            r_sext  <= i_sign_extend;
            o_busy  <= 1'b1;
          end
        end
        StBusy: begin
          if (w_cnt_done) begin
            r_state      <= StDone;
            o_ack        <= 1'b1;
            o_misaligned <= w_mis;
            o_data_out   <= (r_we || w_mis) ? '0 : w_load;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDone: begin
          r_state      <= StIdle;
          o_ack        <= 1'b0;
          o_misaligned <= 1'b0;
          o_busy       <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
